// File: rtl/cg_countdown_pkg.sv
// Shared types for the clock-gate countdown array: channel FSM states and
// the channel mode encoding sampled on load.
package cg_countdown_pkg;

    typedef enum logic [1:0] {
        CG_IDLE,
        CG_LOADED,
        CG_COUNT,
        CG_EXPIRE
    } cg_state_t;

    localparam logic CG_ONESHOT  = 1'b0;
    localparam logic CG_PERIODIC = 1'b1;

endpackage

// File: rtl/cg_countdown_ch.sv
// One countdown channel: holds its gate enable low for max(D,1) non-stalled
// cycles after a load, then expires (one-shot -> IDLE, periodic -> EXPIRE for
// one cycle and reload). Optional macro CG_PERF_CNT_EN adds a saturating
// count of non-stalled gated cycles.
module cg_countdown_ch
    import cg_countdown_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             load,
    input  logic             stop,
    input  logic             mode_in,
    input  logic [CNT_W-1:0] data,
    output logic             gate,
    output logic             done,
    output logic             busy
`ifdef CG_PERF_CNT_EN
    ,
    output logic [31:0]      gated_cycles
`endif
);

    cg_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] reload, reload_nxt;
    logic             mode, mode_nxt;
    logic             done_r, done_nxt;

    // Channel state register; everything freezes while stalled via the
    // next-state logic, which returns the current values under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= CG_IDLE;
            cnt    <= '0;
            reload <= '0;
            mode   <= CG_ONESHOT;
            done_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            reload <= reload_nxt;
            mode   <= mode_nxt;
            done_r <= done_nxt;
        end
    end

    // Next state: stop beats load beats counting. LOADED and COUNT share the
    // expiry test; cnt<=1 also covers a load of 0, so cnt never wraps.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        reload_nxt = reload;
        mode_nxt   = mode;
        done_nxt   = done_r;
        if (!stall) begin
            done_nxt = 1'b0;
            if (stop) begin
                state_nxt = CG_IDLE;
                cnt_nxt   = '0;
            end else if (load) begin
                state_nxt  = CG_LOADED;
                cnt_nxt    = data;
                reload_nxt = data;
                mode_nxt   = mode_in;
            end else begin
                case (state)
                    CG_LOADED, CG_COUNT: begin
                        if (cnt <= CNT_W'(1)) begin
                            state_nxt = (mode == CG_PERIODIC) ? CG_EXPIRE : CG_IDLE;
                            cnt_nxt   = '0;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = CG_COUNT;
                            cnt_nxt   = cnt - CNT_W'(1);
                        end
                    end
                    CG_EXPIRE: begin
                        state_nxt = CG_LOADED;
                        cnt_nxt   = reload;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign gate = (state == CG_IDLE) || (state == CG_EXPIRE);
    // The expiry flag survives a stall but is hidden while the stall lasts.
    assign done = done_r & ~stall;
    assign busy = (state != CG_IDLE);

`ifdef CG_PERF_CNT_EN
    // Gated-cycle counter: cleared by an accepted one-shot load, otherwise
    // counts every non-stalled cycle spent with the gate low, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gated_cycles <= '0;
        end else if (!stall) begin
            if (!stop && load && (mode_in == CG_ONESHOT)) begin
                gated_cycles <= '0;
            end else if (!gate && (gated_cycles != 32'hFFFF_FFFF)) begin
                gated_cycles <= gated_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: rtl/cg_countdown_array.sv
// NUM_CH independent countdown channels driving PE clock-gate enables.
// Optional macro CG_PERF_CNT_EN exposes per-channel gated-cycle counters
// on Gated_Cycles_O.
module cg_countdown_array
    import cg_countdown_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 5
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    Global_Stall_I,
    input  logic [NUM_CH-1:0]       Load_En_I,
    input  logic [NUM_CH-1:0]       Stop_I,
    input  logic [NUM_CH-1:0]       Mode_I,
    input  logic [NUM_CH*CNT_W-1:0] Data_In,
    output logic [NUM_CH-1:0]       Clock_Gate_En_O,
    output logic [NUM_CH-1:0]       Done_O,
    output logic                    Busy_O
`ifdef CG_PERF_CNT_EN
    ,
    output logic [NUM_CH*32-1:0]    Gated_Cycles_O
`endif
);

    logic [NUM_CH-1:0] busy_vec;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        cg_countdown_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk          (Clk),
            .rst_n        (Reset),
            .stall        (Global_Stall_I),
            .load         (Load_En_I[c]),
            .stop         (Stop_I[c]),
            .mode_in      (Mode_I[c]),
            .data         (Data_In[c*CNT_W +: CNT_W]),
            .gate         (Clock_Gate_En_O[c]),
            .done         (Done_O[c]),
            .busy         (busy_vec[c])
`ifdef CG_PERF_CNT_EN
            ,
            .gated_cycles (Gated_Cycles_O[c*32 +: 32])
`endif
        );
    end

    assign Busy_O = |busy_vec;

endmodule

// File: tb/tb_cg_countdown_array.sv
// Scoreboard bench for cg_countdown_array: the stimulus process pushes the
// expected per-cycle outputs computed from a position-in-sequence model, and a
// negedge monitor pops and compares.
module tb_cg_countdown_array;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 5;

    logic                    Clk;
    logic                    Reset;
    logic                    Global_Stall_I;
    logic [NUM_CH-1:0]       Load_En_I;
    logic [NUM_CH-1:0]       Stop_I;
    logic [NUM_CH-1:0]       Mode_I;
    logic [NUM_CH*CNT_W-1:0] Data_In;
    logic [NUM_CH-1:0]       Clock_Gate_En_O;
    logic [NUM_CH-1:0]       Done_O;
    logic                    Busy_O;
`ifdef CG_PERF_CNT_EN
    logic [NUM_CH*32-1:0]    Gated_Cycles_O;
`endif

    cg_countdown_array #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .Global_Stall_I  (Global_Stall_I),
        .Load_En_I       (Load_En_I),
        .Stop_I          (Stop_I),
        .Mode_I          (Mode_I),
        .Data_In         (Data_In),
        .Clock_Gate_En_O (Clock_Gate_En_O),
        .Done_O          (Done_O),
        .Busy_O          (Busy_O)
`ifdef CG_PERF_CNT_EN
        ,
        .Gated_Cycles_O  (Gated_Cycles_O)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [NUM_CH-1:0]    gate;
        logic [NUM_CH-1:0]    done;
        logic                 busy;
        logic [NUM_CH*32-1:0] perf;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 0;

    // Reference model: after a load of D the gate sequence over non-stalled
    // cycles is len=max(D,1) zeros then a one; periodic repeats with period len+1.
    bit          act  [NUM_CH];
    bit          per  [NUM_CH];
    int          len  [NUM_CH];
    int          pos  [NUM_CH];
    int unsigned perf [NUM_CH];

    function automatic logic m_gate(int c);
        if (!act[c]) return 1'b1;
        if (per[c]) return ((pos[c] % (len[c] + 1)) < len[c]) ? 1'b0 : 1'b1;
        return (pos[c] < len[c]) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic m_expiry(int c);
        if (!act[c]) return 1'b0;
        if (per[c]) return (pos[c] % (len[c] + 1)) == len[c];
        return pos[c] == len[c];
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            act[c] = 0; per[c] = 0; len[c] = 1; pos[c] = 0; perf[c] = 0;
        end
    endtask

    task automatic chk(input string name, input logic [127:0] act_v, input logic [127:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act_v, exp_v, $time);
        end
    endtask

    // One cycle of stimulus: drive, predict this cycle's outputs, then advance
    // the model across the next rising edge.
    task automatic step(input bit st, input logic [NUM_CH-1:0] ld, input logic [NUM_CH-1:0] sp,
                        input logic [NUM_CH-1:0] md, input logic [NUM_CH*CNT_W-1:0] dat);
        exp_t e;
        int   d;
        Global_Stall_I = st;
        Load_En_I      = ld;
        Stop_I         = sp;
        Mode_I         = md;
        Data_In        = dat;
        e.busy = 1'b0;
        e.perf = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            e.gate[c] = m_gate(c);
            e.done[c] = !st && m_expiry(c);
            if (act[c] && (per[c] || pos[c] < len[c])) e.busy = 1'b1;
            e.perf[c*32 +: 32] = perf[c];
        end
        q.push_back(e);
        @(posedge Clk);
        if (!st) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (!sp[c] && ld[c] && !md[c]) perf[c] = 0;
                else if (!e.gate[c]) perf[c] = perf[c] + 1;
                if (sp[c]) begin
                    act[c] = 0;
                end else if (ld[c]) begin
                    d      = int'(dat[c*CNT_W +: CNT_W]);
                    act[c] = 1;
                    per[c] = md[c];
                    len[c] = (d == 0) ? 1 : d;
                    pos[c] = 0;
                end else if (act[c]) begin
                    pos[c] = pos[c] + 1;
                end
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, '0, '0, '0);
    endtask

    // Monitor: every cycle the DUT presents outputs, pop and compare.
    always @(negedge Clk) begin
        if (mon_en) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty: got no expected entry at %0t", $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("gate", Clock_Gate_En_O, e.gate);
                chk("done", Done_O, e.done);
                chk("busy", Busy_O, e.busy);
`ifdef CG_PERF_CNT_EN
                chk("gated_cycles", Gated_Cycles_O, e.perf);
`endif
            end
        end
    end

    // Asynchronous reset off the clock edge; outputs must clear immediately.
    task automatic reset_mid();
        mon_en = 0;
        #2 Reset = 1'b0;
        #1;
        chk("rst_async_gate", Clock_Gate_En_O, {NUM_CH{1'b1}});
        chk("rst_async_done", Done_O, '0);
        chk("rst_async_busy", Busy_O, 1'b0);
`ifdef CG_PERF_CNT_EN
        chk("rst_async_perf", Gated_Cycles_O, '0);
`endif
        model_reset();
        q.delete();
        Global_Stall_I = 0; Load_En_I = '0; Stop_I = '0; Mode_I = '0; Data_In = '0;
        @(posedge Clk);
        #3 Reset = 1'b1;
        @(posedge Clk);
        #1 mon_en = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NUM_CH-1:0]       ld, sp, md;
        logic [NUM_CH*CNT_W-1:0] dat;
        bit                      st;

        model_reset();
        Reset = 1'b0; Global_Stall_I = 0; Load_En_I = '0; Stop_I = '0; Mode_I = '0; Data_In = '0;
        #2;
        chk("reset_gate", Clock_Gate_En_O, {NUM_CH{1'b1}});
        chk("reset_done", Done_O, '0);
        chk("reset_busy", Busy_O, 1'b0);
        #5 Reset = 1'b1;
        @(posedge Clk);
        #1 mon_en = 1;

        // reset in the middle of a count
        step(0, 4'b0001, '0, '0, 20'd5);
        idle(2);
        reset_mid();

        // one-shot D=3, then D=0
        step(0, 4'b0001, '0, '0, 20'd3);
        idle(5);
        step(0, 4'b0001, '0, '0, 20'd0);
        idle(3);

        // periodic ch1 D=2 for 9 cycles, then stop
        step(0, 4'b0010, '0, 4'b0010, 20'd2 << CNT_W);
        idle(9);
        step(0, '0, 4'b0010, '0, '0);
        idle(3);

        // stall mid-count on ch2 D=4, with an ignored load during stall
        step(0, 4'b0100, '0, '0, 20'd4 << (2*CNT_W));
        idle(2);
        step(1, '0, '0, '0, '0);
        step(1, 4'b0100, '0, '0, 20'd9 << (2*CNT_W));
        step(1, '0, '0, '0, '0);
        idle(6);

        // stop+load on ch3 while ch0 reloads mid-count
        step(0, 4'b1001, '0, '0, (20'd8 << (3*CNT_W)) | 20'd10);
        idle(3);
        step(0, 4'b1001, 4'b1000, '0, (20'd7 << (3*CNT_W)) | 20'd6);
        idle(8);

        // gated-cycle accounting: one-shot D=4 with stalls, periodic D=1
        step(0, 4'b0011, '0, 4'b0010, (20'd1 << CNT_W) | 20'd4);
        idle(1);
        step(1, '0, '0, '0, '0);
        step(1, '0, '0, '0, '0);
        idle(10);
        step(0, '0, 4'b0010, '0, '0);
        idle(2);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            st = ($urandom_range(7) == 0);
            for (int c = 0; c < NUM_CH; c++) begin
                ld[c] = ($urandom_range(9) == 0);
                sp[c] = ($urandom_range(29) == 0);
                md[c] = 1'($urandom_range(1));
            end
            dat = 20'($urandom);
            step(st, ld, sp, md, dat);
        end
        idle(4);

        mon_en = 0;
        chk("scoreboard_drained", 128'(q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
